// File: rtl/puf_response_capture_if.sv
// PUF response capture bundle: challenge in/out, chain
// oscillator inputs and the response valid/ready handshake.
interface puf_response_capture_if #(
  parameter int CW    = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CW-1:0]    challenge_in;
  logic [CW-1:0]    challenge_out;
  logic             busy;
  logic             osc_q;
  logic             osc_s;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_bit;
  logic             tie;
  logic             sat;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_s;

  modport master (
    output start, challenge_in, osc_q, osc_s, resp_ready,
    input  challenge_out, busy, resp_valid, resp_bit,
    input  tie, sat, count_q, count_s
  );

  modport slave (
    input  start, challenge_in, osc_q, osc_s, resp_ready,
    output challenge_out, busy, resp_valid, resp_bit,
    output tie, sat, count_q, count_s
  );
endinterface

// File: rtl/puf_response_capture.sv
// PUF response capture: drives a challenge, settles, counts
// q/s oscillator edges over a fixed window and compares them.
module puf_response_capture #(
  parameter int CW     = 32,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 8,
  parameter int WINDOW = 1024
) (
  input  logic clk,
  input  logic reset,
  puf_response_capture_if.slave bus
);

  localparam int TW = $clog2(SETTLE + WINDOW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           nstate;
  logic [TW-1:0]    tmr;
  logic [1:0]       q_sy;
  logic [1:0]       s_sy;
  logic             q_h;
  logic             s_h;
  logic             eq;
  logic             es;
  logic [CNT_W-1:0] cq;
  logic [CNT_W-1:0] cs;
  logic [CNT_W-1:0] cq_nx;
  logic [CNT_W-1:0] cs_nx;
  logic             hit_q;
  logic             hit_s;
  logic             sat_acc;
  logic [CW-1:0]    chal_r;
  logic             rbit;
  logic             rtie;
  logic             rsat;
  logic [CNT_W-1:0] rcq;
  logic [CNT_W-1:0] rcs;
  logic             accept;
  logic             settle_end;
  logic             win_end;

  assign accept     = (state == S_IDLE) && bus.start;
  assign settle_end = (state == S_SETTLE)
                   && (tmr == TW'(SETTLE - 1));
  assign win_end    = (state == S_COUNT)
                   && (tmr == TW'(WINDOW - 1));

  assign eq = q_sy[1] & ~q_h;
  assign es = s_sy[1] & ~s_h;

  assign hit_q = (state == S_COUNT) && eq && (cq == '1);
  assign hit_s = (state == S_COUNT) && es && (cs == '1);

  assign cq_nx = ((state == S_COUNT) && eq && (cq != '1))
               ? cq + 1'b1 : cq;
  assign cs_nx = ((state == S_COUNT) && es && (cs != '1))
               ? cs + 1'b1 : cs;

  // Two-flop synchronisers plus one history flop per oscillator
  always_ff @(posedge clk) begin
    if (reset) begin
      q_sy <= '0;
      s_sy <= '0;
      q_h  <= 1'b0;
      s_h  <= 1'b0;
    end else begin
      q_sy <= {q_sy[0], bus.osc_q};
      s_sy <= {s_sy[0], bus.osc_s};
      q_h  <= q_sy[1];
      s_h  <= s_sy[1];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  // FSM next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:   if (bus.start)      nstate = S_SETTLE;
      S_SETTLE: if (settle_end)     nstate = S_COUNT;
      S_COUNT:  if (win_end)        nstate = S_DONE;
      S_DONE:   if (bus.resp_ready) nstate = S_IDLE;
      default:                      nstate = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy       = (state != S_IDLE);
    bus.resp_valid = (state == S_DONE);
  end

  // Phase timer, restarts at each phase boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr <= '0;
    end else if (settle_end || win_end) begin
      tmr <= '0;
    end else if (state == S_SETTLE || state == S_COUNT) begin
      tmr <= tmr + 1'b1;
    end else begin
      tmr <= '0;
    end
  end

  // Saturating edge counters and sticky saturation flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cq      <= '0;
      cs      <= '0;
      sat_acc <= 1'b0;
    end else if (accept) begin
      cq      <= '0;
      cs      <= '0;
      sat_acc <= 1'b0;
    end else if (state == S_COUNT) begin
      cq      <= cq_nx;
      cs      <= cs_nx;
      sat_acc <= sat_acc | hit_q | hit_s;
    end
  end

  // Challenge latch, only updated on accept
  always_ff @(posedge clk) begin
    if (reset)       chal_r <= '0;
    else if (accept) chal_r <= bus.challenge_in;
  end

  // Response registers, captured on the last window edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rbit <= 1'b0;
      rtie <= 1'b0;
      rsat <= 1'b0;
      rcq  <= '0;
      rcs  <= '0;
    end else if (win_end) begin
      rbit <= (cq_nx > cs_nx);
      rtie <= (cq_nx == cs_nx);
      rsat <= sat_acc | hit_q | hit_s;
      rcq  <= cq_nx;
      rcs  <= cs_nx;
    end
  end

  assign bus.challenge_out = chal_r;
  assign bus.resp_bit      = rbit;
  assign bus.tie           = rtie;
  assign bus.sat           = rsat;
  assign bus.count_q       = rcq;
  assign bus.count_s       = rcs;

endmodule

// File: tb/tb_puf_response_capture.sv
// Directed bench for puf_response_capture: two instances,
// one 16-bit and one 4-bit counter build.
module tb_puf_response_capture;

  logic clk;
  logic reset;
  logic oq;
  logic os;
  int   per_q;
  int   per_s;
  int   hq;
  int   hs;
  int   total;
  int   bad;

  puf_response_capture_if #(.CW(32), .CNT_W(16)) b0 ();
  puf_response_capture_if #(.CW(32), .CNT_W(4))  b1 ();

  puf_response_capture #(
    .CW(32), .CNT_W(16), .SETTLE(8), .WINDOW(64)
  ) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  puf_response_capture #(
    .CW(32), .CNT_W(4), .SETTLE(8), .WINDOW(64)
  ) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  assign b0.osc_q = oq;
  assign b0.osc_s = os;
  assign b1.osc_q = oq;
  assign b1.osc_s = os;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // square-wave oscillators, period per_* clk cycles
  always @(negedge clk) begin
    if (hq >= per_q / 2 - 1) begin
      hq = 0;
      oq = ~oq;
    end else begin
      hq = hq + 1;
    end
    if (hs >= per_s / 2 - 1) begin
      hs = 0;
      os = ~os;
    end else begin
      hs = hs + 1;
    end
  end

  task automatic set_osc(input int pq, input int ps);
    per_q = pq;
    per_s = ps;
    repeat (10) @(negedge clk);
  endtask

  task automatic start0(input logic [31:0] c);
    @(negedge clk);
    b0.challenge_in = c;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
  endtask

  task automatic wait0(input int n0, output int lat);
    int n;
    n = n0;
    lat = -1;
    while (n <= 200) begin
      if (b0.resp_valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (b0.busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%0h want=0", b0.busy);
    end
    total++;
    if (b0.resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%0h want=0", b0.resp_valid);
    end
    total++;
    if (b0.challenge_out !== 32'h0) begin
      bad++; $display("FAIL rst_chal got=%0h want=0", b0.challenge_out);
    end
    total++;
    if (b0.count_q !== 16'd0 || b0.count_s !== 16'd0) begin
      bad++;
      $display("FAIL rst_counts got=%0d/%0d want=0/0",
               b0.count_q, b0.count_s);
    end
    total++;
    if ({b0.resp_bit, b0.tie, b0.sat} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags got=%b want=000",
               {b0.resp_bit, b0.tie, b0.sat});
    end
    total++;
    if (b1.busy !== 1'b0 || b1.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_dut1 got=%b%b want=00",
               b1.busy, b1.resp_valid);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    set_osc(4, 8);
    start0(32'hA5A5_0F0F);
    total++;
    if (b0.challenge_out !== 32'hA5A5_0F0F) begin
      bad++;
      $display("FAIL basic_chal got=%0h want=a5a50f0f",
               b0.challenge_out);
    end
    total++;
    if (b0.busy !== 1'b1) begin
      bad++; $display("FAIL basic_busy got=%0h want=1", b0.busy);
    end
    wait0(1, lat);
    total++;
    if (lat !== 73) begin
      bad++; $display("FAIL basic_lat got=%0d want=73", lat);
    end
    total++;
    if (b0.count_q !== 16'd16 || b0.count_s !== 16'd8) begin
      bad++;
      $display("FAIL basic_counts got=%0d/%0d want=16/8",
               b0.count_q, b0.count_s);
    end
    total++;
    if ({b0.resp_bit, b0.tie, b0.sat} !== 3'b100) begin
      bad++;
      $display("FAIL basic_flags got=%b want=100",
               {b0.resp_bit, b0.tie, b0.sat});
    end
  endtask

  task automatic test_swap;
    int lat;
    set_osc(8, 4);
    start0(32'h0000_0001);
    wait0(1, lat);
    total++;
    if (lat !== 73) begin
      bad++; $display("FAIL swap_lat got=%0d want=73", lat);
    end
    total++;
    if (b0.count_q !== 16'd8 || b0.count_s !== 16'd16) begin
      bad++;
      $display("FAIL swap_counts got=%0d/%0d want=8/16",
               b0.count_q, b0.count_s);
    end
    total++;
    if ({b0.resp_bit, b0.tie} !== 2'b00) begin
      bad++;
      $display("FAIL swap_flags got=%b want=00",
               {b0.resp_bit, b0.tie});
    end
  endtask

  task automatic test_equal;
    int lat;
    set_osc(4, 4);
    start0(32'h0000_0002);
    wait0(1, lat);
    total++;
    if (b0.count_q !== 16'd16 || b0.count_s !== 16'd16) begin
      bad++;
      $display("FAIL equal_counts got=%0d/%0d want=16/16",
               b0.count_q, b0.count_s);
    end
    total++;
    if ({b0.resp_bit, b0.tie, b0.sat} !== 3'b010) begin
      bad++;
      $display("FAIL equal_flags got=%b want=010",
               {b0.resp_bit, b0.tie, b0.sat});
    end
  endtask

  task automatic test_sat;
    int n;
    int lat;
    set_osc(2, 8);
    @(negedge clk);
    b1.challenge_in = 32'h5555_AAAA;
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    n = 1;
    lat = -1;
    while (n <= 200) begin
      if (b1.resp_valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (lat !== 73) begin
      bad++; $display("FAIL sat_lat got=%0d want=73", lat);
    end
    total++;
    if (b1.count_q !== 4'd15 || b1.count_s !== 4'd8) begin
      bad++;
      $display("FAIL sat_counts got=%0d/%0d want=15/8",
               b1.count_q, b1.count_s);
    end
    total++;
    if ({b1.resp_bit, b1.tie, b1.sat} !== 3'b101) begin
      bad++;
      $display("FAIL sat_flags got=%b want=101",
               {b1.resp_bit, b1.tie, b1.sat});
    end
  endtask

  task automatic test_handshake;
    int  lat;
    logic ok;
    set_osc(4, 8);
    b0.resp_ready = 1'b0;
    start0(32'h1234_5678);
    repeat (29) @(negedge clk);
    b0.challenge_in = 32'hFFFF_FFFF;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    total++;
    if (b0.challenge_out !== 32'h1234_5678) begin
      bad++;
      $display("FAIL hs_chal_mid got=%0h want=12345678",
               b0.challenge_out);
    end
    wait0(31, lat);
    total++;
    if (lat !== 73) begin
      bad++; $display("FAIL hs_lat got=%0d want=73", lat);
    end
    for (int k = 0; k < 5; k++) begin
      ok = b0.resp_valid && b0.count_q == 16'd16
        && b0.count_s == 16'd8 && b0.resp_bit
        && !b0.tie && !b0.sat;
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL hs_hold k=%0d got=%b %0d/%0d %b%b%b want=1 16/8 100",
                 k, b0.resp_valid, b0.count_q, b0.count_s,
                 b0.resp_bit, b0.tie, b0.sat);
      end
      @(negedge clk);
    end
    b0.resp_ready = 1'b1;
    b0.challenge_in = 32'hDEAD_BEEF;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    total++;
    if (b0.resp_valid !== 1'b0 || b0.busy !== 1'b0) begin
      bad++;
      $display("FAIL hs_release got=%b%b want=00",
               b0.resp_valid, b0.busy);
    end
    total++;
    if (b0.challenge_out !== 32'h1234_5678) begin
      bad++;
      $display("FAIL hs_chal_done got=%0h want=12345678",
               b0.challenge_out);
    end
    @(negedge clk);
    total++;
    if (b0.busy !== 1'b0) begin
      bad++; $display("FAIL hs_idle got=%0h want=0", b0.busy);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    set_osc(4, 8);
    start0(32'hCAFE_F00D);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (b0.busy !== 1'b0 || b0.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_state got=%b%b want=00",
               b0.busy, b0.resp_valid);
    end
    total++;
    if (b0.count_q !== 16'd0 || b0.count_s !== 16'd0) begin
      bad++;
      $display("FAIL mid_counts got=%0d/%0d want=0/0",
               b0.count_q, b0.count_s);
    end
    total++;
    if (b0.challenge_out !== 32'h0) begin
      bad++;
      $display("FAIL mid_chal got=%0h want=0", b0.challenge_out);
    end
    start0(32'hA5A5_0F0F);
    wait0(1, lat);
    total++;
    if (lat !== 73) begin
      bad++; $display("FAIL mid_lat got=%0d want=73", lat);
    end
    total++;
    if (b0.count_q !== 16'd16 || b0.count_s !== 16'd8
        || b0.resp_bit !== 1'b1) begin
      bad++;
      $display("FAIL mid_rerun got=%0d/%0d %b want=16/8 1",
               b0.count_q, b0.count_s, b0.resp_bit);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    oq    = 1'b0;
    os    = 1'b0;
    hq    = 0;
    hs    = 0;
    per_q = 4;
    per_s = 8;
    reset = 1'b1;
    b0.start        = 1'b0;
    b0.challenge_in = '0;
    b0.resp_ready   = 1'b1;
    b1.start        = 1'b0;
    b1.challenge_in = '0;
    b1.resp_ready   = 1'b1;
    test_reset;
    test_basic;
    test_swap;
    test_equal;
    test_sat;
    test_handshake;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
